// File: rtl/uart_tx_ctrl.sv
// UART transmitter: start bit, LSB-first data, optional even parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to insert the even-parity bit after the data bits.
module uart_tx_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(OVS);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVS - 1);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     tick_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_bit;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction
`endif

    assign tx_ready = (state == IDLE);
    assign tx_busy  = ~tx_ready;
    assign bit_end  = baud_tick && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE && baud_tick)
                tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg    <= tx_data;
                        tick_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b0;
                        state    <= START;
`ifdef UART_TX_PARITY_EN
                        par_bit  <= even_parity(tx_data);
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= par_bit;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    // bit_idx counts completed stop bits so two-stop frames reuse the OVS wrap
                    if (bit_end) begin
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            tx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level reference model plus hand-decoded frame table.
module tb_uart_tx_ctrl;

    localparam int DB = 8;
    localparam int OV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        int         inst;
        logic [7:0] data;
        string      seq;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic       tx_valid, tx_valid2;
    logic [7:0] tx_data, tx_data2;
    logic       tx_ready, tx, tx_busy, tx_done;
    logic       tx_ready2, tx2, tx_busy2, tx_done2;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         rand_ticks = 0;
    bit         m_act[2];
    int         m_tk[2];
    logic [7:0] m_dat[2];
    int         done_seen[2];
    vec_t       tbl[5];

    always #5 clk = ~clk;

    uart_tx_ctrl #(.DATA_BITS(DB), .OVS(OV), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    uart_tx_ctrl #(.DATA_BITS(DB), .OVS(OV), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(tx_data2),
        .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx(tx2), .tx_busy(tx_busy2),
        .tx_done(tx_done2)
    );

    // Frame bit idx on the line: 0 start, 1..DB data LSB first, optional parity, then stop.
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
        if (PAR == 1 && idx == DB + 1) return ^d;
        return 1'b1;
    endfunction

    function automatic logic [3:0] outs(input int i);
        return (i == 0) ? {tx, tx_ready, tx_busy, tx_done}
                        : {tx2, tx_ready2, tx_busy2, tx_done2};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Line position is simply ticks_since_accept / OVS; the frame ends after nb*OVS ticks.
    task automatic model_step(input int i, input int stopb, input logic v, input logic tk,
                              input logic [7:0] d);
        logic [3:0] exp;
        logic       done_now;
        int         nb;
        done_now = 1'b0;
        nb = 1 + DB + PAR + stopb;
        if (!rst) begin
            m_act[i] = 1'b0;
        end else if (!m_act[i]) begin
            if (v) begin
                m_act[i] = 1'b1;
                m_tk[i]  = 0;
                m_dat[i] = d;
            end
        end else if (tk) begin
            m_tk[i]++;
            if (m_tk[i] == nb * OV) begin
                m_act[i] = 1'b0;
                done_now = 1'b1;
            end
        end
        if (m_act[i]) exp = {exp_bit(m_dat[i], m_tk[i] / OV), 1'b0, 1'b1, 1'b0};
        else          exp = {1'b1, 1'b1, 1'b0, done_now};
        check($sformatf("outs%0d", i), 32'(outs(i)), 32'(exp));
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
        cyc++;
        model_step(0, 1, tx_valid,  baud_tick, tx_data);
        model_step(1, 2, tx_valid2, baud_tick, tx_data2);
        if (tx_done)  done_seen[0]++;
        if (tx_done2) done_seen[1]++;
        baud_tick = rand_ticks ? ($urandom_range(0, 2) == 0) : (cyc % 4 == 0);
    endtask

    task automatic send_frame(input int e);
        int         i, n, k, c, t_rise, t_done;
        logic       tk;
        logic [3:0] o;
        logic [7:0] d;
        string      s;
        i = tbl[e].inst; d = tbl[e].data; s = tbl[e].seq;
        n = 0; k = 0; c = 0; t_rise = -1; t_done = -1;
        if (i == 0) begin tx_data = d; tx_valid = 1'b1; end
        else        begin tx_data2 = d; tx_valid2 = 1'b1; end
        tick_cycle();
        tx_valid = 1'b0; tx_valid2 = 1'b0;
        // Scramble the input bus so a late re-sample would corrupt the frame
        if (i == 0) tx_data = ~d; else tx_data2 = ~d;
        for (int guard = 0; guard < 4000 && t_done < 0; guard++) begin
            tk = baud_tick;
            tick_cycle();
            c++;
            if (tk) n++;
            o = outs(i);
            if (tk && k < s.len() && n == OV * k + OV / 2) begin
                check($sformatf("bit%0d_of_%0h", k, d), 32'(o[3]), 32'(s[k] == 8'h31));
                k++;
            end
            if (t_rise < 0 && o[3]) t_rise = c;
            if (o[0]) t_done = c;
        end
        check($sformatf("bits_seen_%0h", d), 32'(k), 32'(s.len()));
        check($sformatf("done_seen_%0h", d), 32'(t_done >= 0), 32'd1);
        if (d[0] && t_done >= 0)
            check($sformatf("frame_clks_%0h", d), 32'(t_done - t_rise), 32'((s.len() - 1) * OV * 4));
    endtask

    initial begin
        int d0, gap, phase, n;
        logic tk;

`ifdef UART_TX_PARITY_EN
        tbl[0] = '{0, 8'hA5, "01010010101"};
        tbl[1] = '{0, 8'h07, "01110000011"};
        tbl[2] = '{0, 8'h55, "01010101001"};
        tbl[3] = '{0, 8'h3C, "00011110001"};
        tbl[4] = '{1, 8'hFF, "011111111011"};
`else
        tbl[0] = '{0, 8'hA5, "0101001011"};
        tbl[1] = '{0, 8'h07, "0111000001"};
        tbl[2] = '{0, 8'h55, "0101010101"};
        tbl[3] = '{0, 8'h3C, "0001111001"};
        tbl[4] = '{1, 8'hFF, "01111111111"};
`endif
        m_act = '{0, 0};
        m_tk = '{0, 0};
        done_seen = '{0, 0};
        rst = 1'b0; baud_tick = 1'b0;
        tx_valid = 1'b0; tx_valid2 = 1'b0; tx_data = 8'h00; tx_data2 = 8'h00;

        #27;
        check("reset_outs0", 32'(outs(0)), 32'(4'b1100));
        check("reset_outs1", 32'(outs(1)), 32'(4'b1100));
        rst = 1'b1;

        // Idle with ticks running and no valid
        repeat (1000) tick_cycle();
        check("idle_no_done", 32'(done_seen[0] + done_seen[1]), 32'd0);

        for (int e = 0; e < 4; e++) begin
            send_frame(e);
            repeat (3) tick_cycle();
        end

        // tx_valid held high across two frames
        d0 = done_seen[0];
        tx_data = 8'h55; tx_valid = 1'b1;
        tick_cycle();
        tx_data = 8'hAA;
        gap = 0; phase = 0;
        for (int guard = 0; guard < 4000 && phase < 2; guard++) begin
            tick_cycle();
            if (phase == 0) begin
                if (tx_ready) gap++;
                else if (gap > 0) begin phase = 1; tx_valid = 1'b0; end
            end else if (done_seen[0] == d0 + 2) begin
                phase = 2;
            end
        end
        tx_valid = 1'b0;
        check("b2b_idle_gap", 32'(gap), 32'd1);
        check("b2b_done_count", 32'(done_seen[0] - d0), 32'd2);
        repeat (20) tick_cycle();
        check("b2b_no_third", 32'(done_seen[0] - d0), 32'd2);

        // Abort mid data bit 3
        tx_data = 8'h3C; tx_valid = 1'b1;
        tick_cycle();
        tx_valid = 1'b0;
        n = 0;
        for (int guard = 0; guard < 2000 && n < 4 * OV + OV / 2; guard++) begin
            tk = baud_tick;
            tick_cycle();
            if (tk) n++;
        end
        check("abort_reached_bit3", 32'(n), 32'(4 * OV + OV / 2));
        check("abort_pre_busy", 32'(tx_busy), 32'd1);
        d0 = done_seen[0];
        #2 rst = 1'b0;
        #1;
        check("abort_async_outs", 32'(outs(0)), 32'(4'b1100));
        repeat (3) tick_cycle();
        rst = 1'b1;
        repeat (300) tick_cycle();
        check("abort_no_done", 32'(done_seen[0]), 32'(d0));
        send_frame(3);

        // Two stop bits
        send_frame(4);
        repeat (3) tick_cycle();

        // Random traffic with irregular, sometimes back-to-back ticks
        rand_ticks = 1'b1;
        for (int j = 0; j < 10000; j++) begin
            tick_cycle();
            tx_valid  = ($urandom_range(0, 5) == 0);
            tx_data   = 8'($urandom);
            tx_valid2 = ($urandom_range(0, 5) == 0);
            tx_data2  = 8'($urandom);
        end
        rand_ticks = 1'b0;
        tx_valid = 1'b0; tx_valid2 = 1'b0;
        for (int guard = 0; guard < 5000 && (m_act[0] || m_act[1]); guard++) tick_cycle();
        check("drain_idle", 32'(tx_busy | tx_busy2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
